// File: rtl/sw_evt_sequencer.sv
// Switch-event sequencer: services a switch PIO over a simple Avalon-MM master
// port. After reset it programs irq_mask. On irq it reads edge_capture, clears it,
// reads the switch levels and buffers {capture, level} events for a consumer.
// A cfg_mask_wr request is latched and later written to irq_mask; it takes
// priority over irq service.
//
// Build option: define SW_EVT_FIFO_EN for a 4-entry event FIFO; otherwise the
// event buffer is a single register.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   irq                   PIO interrupt
//   avm_*                 PIO register access (address 0 data, 2 mask, 3 capture)
//   cfg_mask_wr/cfg_mask  irq_mask rewrite request and value
//   evt_valid/evt_ready   event handshake; evt_capture/evt_level event payload
//   busy                  high whenever the sequencer is not idle
module sw_evt_sequencer #(
  parameter int unsigned     SW_W      = 18,
  parameter logic [SW_W-1:0] MASK_INIT = 18'h3FFFF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            irq,
  output logic [1:0]      avm_address,
  output logic            avm_chipselect,
  output logic            avm_write_n,
  output logic [31:0]     avm_writedata,
  input  logic [31:0]     avm_readdata,
  input  logic            cfg_mask_wr,
  input  logic [SW_W-1:0] cfg_mask,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [SW_W-1:0] evt_capture,
  output logic [SW_W-1:0] evt_level,
  output logic            busy
);

  typedef enum logic [2:0] {
    StInit, StIdle, StMaskWr, StRdCap, StWrClr, StRdDat, StPush
  } state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [SW_W-1:0] pend_mask_q, pend_mask_d;
  logic [SW_W-1:0] cap_q;
  logic [SW_W-1:0] lvl_q;
  logic            lvl_held_q;
  logic [SW_W-1:0] lvl_cur;
  logic            buf_full;
  logic            pop, push, space;
  logic            cs, wr_n;
  logic [1:0]      addr;
  logic [SW_W-1:0] wdata;
  logic            unused_rd;

  assign unused_rd = ^avm_readdata[31:SW_W];

  // Level is sampled once on the first PUSH cycle and held while the buffer is full.
  assign lvl_cur = lvl_held_q ? lvl_q : avm_readdata[SW_W-1:0];
  assign pop     = evt_valid & evt_ready;
  assign space   = ~buf_full | pop;
  assign push    = (state_q == StPush) && (cap_q != '0) && space;

  // A request arriving this cycle counts as pending so it wins over a coincident irq.
  assign pend_d      = cfg_mask_wr | (pend_q & (state_q != StMaskWr));
  assign pend_mask_d = cfg_mask_wr ? cfg_mask : pend_mask_q;

  always_comb begin
    state_d = state_q;
    cs      = 1'b0;
    wr_n    = 1'b1;
    addr    = 2'd0;
    wdata   = '0;
    busy    = 1'b1;
    unique case (state_q)
      StInit: begin
        cs      = 1'b1;
        wr_n    = 1'b0;
        addr    = 2'd2;
        wdata   = MASK_INIT;
        state_d = StIdle;
      end
      StIdle: begin
        busy = 1'b0;
        if (pend_q || cfg_mask_wr) state_d = StMaskWr;
        else if (irq)              state_d = StRdCap;
      end
      StMaskWr: begin
        cs      = 1'b1;
        wr_n    = 1'b0;
        addr    = 2'd2;
        wdata   = pend_mask_q;
        state_d = StIdle;
      end
      StRdCap: begin
        cs      = 1'b1;
        addr    = 2'd3;
        state_d = StWrClr;
      end
      StWrClr: begin
        cs      = 1'b1;
        wr_n    = 1'b0;
        addr    = 2'd3;
        state_d = StRdDat;
      end
      StRdDat: begin
        cs      = 1'b1;
        addr    = 2'd0;
        state_d = StPush;
      end
      StPush: begin
        if ((cap_q == '0) || space) state_d = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // Bus is forced quiet while reset is asserted, even though the state is INIT.
  assign avm_chipselect = cs & reset_n;
  assign avm_write_n    = wr_n | ~reset_n;
  assign avm_address    = reset_n ? addr : 2'd0;
  assign avm_writedata  = reset_n ? {{(32-SW_W){1'b0}}, wdata} : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      pend_q      <= 1'b0;
      pend_mask_q <= '0;
      cap_q       <= '0;
      lvl_q       <= '0;
      lvl_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_mask_q <= pend_mask_d;
      if (state_q == StWrClr) cap_q <= avm_readdata[SW_W-1:0];
      if ((state_q == StPush) && (state_d == StPush)) begin
        lvl_q      <= lvl_cur;
        lvl_held_q <= 1'b1;
      end else begin
        lvl_held_q <= 1'b0;
      end
    end
  end

`ifdef SW_EVT_FIFO_EN
  localparam int unsigned Depth = 4;

  logic [2*SW_W-1:0] mem_q [Depth];
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        cnt_q;

  assign buf_full                 = (cnt_q == 3'd4);
  assign evt_valid                = (cnt_q != 3'd0);
  assign {evt_capture, evt_level} = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {cap_q, lvl_cur};
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      cnt_q <= cnt_q + 3'd1;
      else if (pop && !push) cnt_q <= cnt_q - 3'd1;
    end
  end
`else
  logic              vld_q;
  logic [2*SW_W-1:0] ent_q;

  assign buf_full                 = vld_q;
  assign evt_valid                = vld_q;
  assign {evt_capture, evt_level} = ent_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      ent_q <= '0;
    end else begin
      if (push) ent_q <= {cap_q, lvl_cur};
      vld_q <= push | (vld_q & ~pop);
    end
  end
`endif

endmodule

// File: doc/sw_evt_sequencer.md
SW_EVT_SEQUENCER -- requirements
Module: sw_evt_sequencer

Interface
REQ-001 Parameter MASK_INIT, default 18'h3FFFF, irq_mask value written to the switch PIO after reset.
REQ-002 Parameter SW_W, default 18, switch PIO data width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 irq  in  1  switch PIO interrupt (edge_capture & irq_mask nonzero).
REQ-006 avm_address  out  2  PIO register select: 0 data, 2 irq_mask, 3 edge_capture.
REQ-007 avm_chipselect  out  1  PIO access strobe.
REQ-008 avm_write_n  out  1  active-low write.
REQ-009 avm_writedata  out  32  write data; bits 31:SW_W are zero.
REQ-010 avm_readdata  in  32  PIO read data; registered, valid the cycle after the address is presented.
REQ-011 cfg_mask_wr  in  1  one-cycle request to rewrite irq_mask.
REQ-012 cfg_mask  in  SW_W  new irq_mask value, sampled when cfg_mask_wr=1.
REQ-013 evt_valid  out  1  event available.
REQ-014 evt_ready  in  1  consumer accepts event; transfer when evt_valid & evt_ready.
REQ-015 evt_capture  out  SW_W  captured falling-edge bits of the head event.
REQ-016 evt_level  out  SW_W  switch levels read after the capture.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: INIT, IDLE, MASK_WR, RD_CAP, WR_CLR, RD_DAT, PUSH.
REQ-019 INIT: one-cycle write, address 2, data MASK_INIT; next IDLE.
REQ-020 IDLE: chipselect=0, write_n=1; priority: pending mask request > irq=1 > stay.
REQ-021 cfg_mask_wr is latched into a pending flag plus value in any state; a later request before service overwrites the value.
REQ-022 MASK_WR: one-cycle write, address 2, latched value; clears pending flag; next IDLE.
REQ-023 RD_CAP: read, address 3; next WR_CLR.
REQ-024 WR_CLR: write, address 3, data 0; cap register <= avm_readdata[SW_W-1:0] at end of cycle; next RD_DAT.
REQ-025 RD_DAT: read, address 0; next PUSH.
REQ-026 PUSH: level = avm_readdata[SW_W-1:0]; cap==0 -> drop, no push, next IDLE; cap!=0 and buffer not full -> push {cap, level}, next IDLE; buffer full -> hold in PUSH, re-sampling nothing, until space exists.
REQ-027 Service latency irq-to-push: 4 cycles from IDLE exit when buffer has space.
REQ-028 Edges captured by the PIO during the RD_CAP or WR_CLR cycles are lost; accepted.
REQ-029 Buffer FIFO order; push and pop in same cycle when full is allowed and keeps count unchanged.
REQ-030 evt_capture/evt_level stable while evt_valid=1 and evt_ready=0.
REQ-031 avm_chipselect=1 only in INIT, MASK_WR, RD_CAP, WR_CLR, RD_DAT; avm_write_n=0 only in INIT, MASK_WR, WR_CLR.

Reset
REQ-032 reset_n=0 asynchronously forces state INIT, buffer empty, pending flag 0, cap/level 0.
REQ-033 Outputs during reset: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, evt_valid 0, evt_capture 0, evt_level 0, busy 1.
REQ-034 Reset mid-access abandons the access; no partial event is pushed; INIT rewrites MASK_INIT after release.

Configuration
REQ-035 Macro SW_EVT_FIFO_EN defined: event buffer is a 4-entry FIFO.
REQ-036 SW_EVT_FIFO_EN undefined: event buffer is a single register (depth 1); all other behaviour identical.

Verification
REQ-037 Release reset -> first cycle: chipselect=1, write_n=0, address=2, writedata=0x3FFFF; then IDLE, busy=0.
REQ-038 PIO model sets capture 0x00005, data 0x3FFFA, irq=1, evt_ready=1 -> accesses rd3, wr3(0), rd0; event cap=0x00005, level=0x3FFFA; irq drops.
REQ-039 irq=1 with capture reading 0 -> rd3, wr3, rd0, no evt_valid, back to IDLE.
REQ-040 evt_ready=0, five irq events (FIFO build) -> four buffered, FSM holds in PUSH, busy=1; one pop -> fifth pushed, order preserved.
REQ-041 cfg_mask_wr=1 cfg_mask=0x00F00 simultaneous with irq=1 in IDLE -> mask write to address 2 first, then irq service.
REQ-042 reset_n low during WR_CLR -> no event pushed; after release INIT write occurs, evt_valid=0.
